// File: rtl/mmu_cp0_regfile_pkg.sv
// Shared types and constants for the MMU CP0 register responder:
// register select codes, TLB op codes, the TLB entry layout and field masks.
package mmu_cp0_regfile_pkg;

  localparam int MMU_REG_W = 4;

  typedef enum logic [MMU_REG_W-1:0] {
    REG_NONE     = 4'd0,
    REG_INDEX    = 4'd1,
    REG_RANDOM   = 4'd2,
    REG_ENTRYLO0 = 4'd3,
    REG_ENTRYLO1 = 4'd4,
    REG_CTX      = 4'd5,
    REG_PAGEMASK = 4'd6,
    REG_WIRED    = 4'd7,
    REG_ENTRYHI  = 4'd8
  } mmu_reg_e;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_TLBR  = 3'd1,
    OP_TLBWI = 3'd2,
    OP_TLBWR = 3'd3,
    OP_TLBP  = 3'd4
  } tlb_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_PROBE = 2'd2,
    ST_DONE  = 2'd3
  } tlb_state_e;

  // One TLB entry: shared VPN2/ASID/mask/G tag plus an even and an odd page.
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic [11:0] mask;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  localparam int TLB_ENTRY_W = $bits(tlb_entry_t);

  // Writable bits of each register; everything else reads back as 0.
  localparam logic [31:0] ENTRYLO_MASK  = 32'h03FF_FFFF;
  localparam logic [31:0] ENTRYHI_MASK  = 32'hFFFF_E0FF;
  localparam logic [31:0] CTX_MASK      = 32'hFFFF_FFF0;
  localparam logic [31:0] PAGEMASK_MASK = 32'h01FF_E000;

  // Rebuild the 26 implemented EntryLo bits from one page of an entry.
  function automatic logic [25:0] lo_pack(input logic [19:0] pfn, input logic [2:0] c,
                                          input logic d, input logic v, input logic g);
    return {pfn, c, d, v, g};
  endfunction

endpackage

// File: rtl/mmu_cp0_regfile_if.sv
// CP0 register-access and TLB-op bus between the CP0 block (master) and the MMU (slave).
interface mmu_cp0_regfile_if;
  import mmu_cp0_regfile_pkg::*;

  mmu_reg_e    mmu_reg;
  logic        readMMUReg;
  logic        writeMMUReg;
  logic [31:0] mmu_dataIn;
  logic [31:0] mmu_dataOut;
  tlb_op_e     tlb_op;
  logic        tlb_op_valid;
  logic        tlb_busy;
  logic        tlb_done;

  modport master (
    output mmu_reg, readMMUReg, writeMMUReg, mmu_dataIn, tlb_op, tlb_op_valid,
    input  mmu_dataOut, tlb_busy, tlb_done
  );

  modport slave (
    input  mmu_reg, readMMUReg, writeMMUReg, mmu_dataIn, tlb_op, tlb_op_valid,
    output mmu_dataOut, tlb_busy, tlb_done
  );

endinterface

// File: rtl/mmu_cp0_regfile_tlb_entry_array.sv
// TLB entry storage: one synchronous write port, two combinational read ports
// (port A for the op FSM, port B for the translation path).
module mmu_cp0_regfile_tlb_entry_array
  import mmu_cp0_regfile_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  tlb_entry_t       wdata_i,
  input  logic [IDX_W-1:0] raddr_a_i,
  output tlb_entry_t       rdata_a_o,
  input  logic [IDX_W-1:0] raddr_b_i,
  output tlb_entry_t       rdata_b_o
);

  tlb_entry_t mem_q [NUM_ENTRIES];

  // Entry storage; reset invalidates every entry by clearing it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/mmu_cp0_regfile.sv
// MMU-side CP0 register file: Index/Random/EntryLo0/1/Context/PageMask/Wired/EntryHi,
// the TLB entry array, and the TLBR/TLBWI/TLBWR/TLBP sequencer.
module mmu_cp0_regfile
  import mmu_cp0_regfile_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  mmu_cp0_regfile_if.slave       bus,
  input  logic                   exc_tlb,
  input  logic [31:0]            exc_badVAddr,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [TLB_ENTRY_W-1:0] rd_entry
);

  localparam logic [IDX_W-1:0] RAND_MAX = IDX_W'(NUM_ENTRIES - 1);

  logic             idx_p_q, idx_p_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] random_q, random_d;
  logic [IDX_W-1:0] wired_q, wired_d;
  logic [25:0]      lo0_q, lo0_d, lo1_q, lo1_d;
  logic [8:0]       ctx_base_q, ctx_base_d;
  logic [18:0]      ctx_bad_q, ctx_bad_d;
  logic [11:0]      mask_q, mask_d;
  logic [18:0]      hi_vpn2_q, hi_vpn2_d;
  logic [7:0]       hi_asid_q, hi_asid_d;
  logic [31:0]      dout_q, dout_d, rd_val;

  tlb_state_e       state_q;
  tlb_op_e          op_q;
  logic [IDX_W-1:0] cnt_q;
  logic             busy_q, done_q;

  tlb_entry_t       ent_a, ent_b, wr_entry;
  logic [IDX_W-1:0] raddr_a, waddr;
  logic             we, probe_hit;
  logic             unused_badvaddr;

  assign unused_badvaddr = ^exc_badVAddr[12:0];

  // Port A follows the probe counter during TLBP, otherwise Index.
  assign raddr_a = (state_q == ST_PROBE) ? cnt_q : idx_q;
  assign we      = (state_q == ST_EXEC) && (op_q == OP_TLBWI || op_q == OP_TLBWR);
  assign waddr   = (op_q == OP_TLBWR) ? random_q : idx_q;

  mmu_cp0_regfile_tlb_entry_array #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W)) u_array (
    .clk      (clk),
    .rst      (rst),
    .we_i     (we),
    .waddr_i  (waddr),
    .wdata_i  (wr_entry),
    .raddr_a_i(raddr_a),
    .rdata_a_o(ent_a),
    .raddr_b_i(rd_idx),
    .rdata_b_o(ent_b)
  );

  assign rd_entry = ent_b;

  // Entry image built from the registers; G is shared, so both pages must be global.
  always_comb begin
    wr_entry      = '0;
    wr_entry.vpn2 = hi_vpn2_q;
    wr_entry.asid = hi_asid_q;
    wr_entry.mask = mask_q;
    wr_entry.g    = lo0_q[0] & lo1_q[0];
    wr_entry.pfn0 = lo0_q[25:6];
    wr_entry.c0   = lo0_q[5:3];
    wr_entry.d0   = lo0_q[2];
    wr_entry.v0   = lo0_q[1];
    wr_entry.pfn1 = lo1_q[25:6];
    wr_entry.c1   = lo1_q[5:3];
    wr_entry.d1   = lo1_q[2];
    wr_entry.v1   = lo1_q[1];
  end

  // Probe compare: VPN2 bits covered by the entry's page mask are don't-care.
  assign probe_hit = (((ent_a.vpn2 ^ hi_vpn2_q) & ~{7'b0, ent_a.mask}) == 19'b0) &&
                     (ent_a.g || (ent_a.asid == hi_asid_q));

  // Read mux assembling each register's architectural view.
  always_comb begin
    rd_val = 32'b0;
    case (bus.mmu_reg)
      REG_INDEX:    rd_val = {idx_p_q, {(31-IDX_W){1'b0}}, idx_q};
      REG_RANDOM:   rd_val = {{(32-IDX_W){1'b0}}, random_q};
      REG_ENTRYLO0: rd_val = {6'b0, lo0_q};
      REG_ENTRYLO1: rd_val = {6'b0, lo1_q};
      REG_CTX:      rd_val = {ctx_base_q, ctx_bad_q, 4'b0};
      REG_PAGEMASK: rd_val = {7'b0, mask_q, 13'b0};
      REG_WIRED:    rd_val = {{(32-IDX_W){1'b0}}, wired_q};
      REG_ENTRYHI:  rd_val = {hi_vpn2_q, 5'b0, hi_asid_q};
      default:      rd_val = 32'b0;
    endcase
  end

  // Register next state: Random stepping, then software writes, then op results,
  // with the exception load last so it wins on the VPN2/BadVPN2 fields.
  always_comb begin
    idx_p_d    = idx_p_q;
    idx_d      = idx_q;
    wired_d    = wired_q;
    lo0_d      = lo0_q;
    lo1_d      = lo1_q;
    ctx_base_d = ctx_base_q;
    ctx_bad_d  = ctx_bad_q;
    mask_d     = mask_q;
    hi_vpn2_d  = hi_vpn2_q;
    hi_asid_d  = hi_asid_q;
    random_d   = (random_q > wired_q) ? random_q - IDX_W'(1) : RAND_MAX;
    dout_d     = bus.readMMUReg ? rd_val : dout_q;

    if (bus.writeMMUReg) begin
      case (bus.mmu_reg)
        REG_INDEX: begin
          idx_p_d = bus.mmu_dataIn[31];
          idx_d   = bus.mmu_dataIn[IDX_W-1:0];
        end
        REG_ENTRYLO0: lo0_d = bus.mmu_dataIn[25:0];
        REG_ENTRYLO1: lo1_d = bus.mmu_dataIn[25:0];
        REG_CTX: begin
          ctx_base_d = bus.mmu_dataIn[31:23];
          ctx_bad_d  = bus.mmu_dataIn[22:4];
        end
        REG_PAGEMASK: mask_d = bus.mmu_dataIn[24:13];
        REG_WIRED: begin
          wired_d  = bus.mmu_dataIn[IDX_W-1:0];
          random_d = RAND_MAX;
        end
        REG_ENTRYHI: begin
          hi_vpn2_d = bus.mmu_dataIn[31:13];
          hi_asid_d = bus.mmu_dataIn[7:0];
        end
        default: ;
      endcase
    end

    if (state_q == ST_EXEC && op_q == OP_TLBR) begin
      hi_vpn2_d = ent_a.vpn2;
      hi_asid_d = ent_a.asid;
      mask_d    = ent_a.mask;
      lo0_d     = lo_pack(ent_a.pfn0, ent_a.c0, ent_a.d0, ent_a.v0, ent_a.g);
      lo1_d     = lo_pack(ent_a.pfn1, ent_a.c1, ent_a.d1, ent_a.v1, ent_a.g);
    end

    if (state_q == ST_PROBE) begin
      if (probe_hit) begin
        idx_p_d = 1'b0;
        idx_d   = cnt_q;
      end else if (cnt_q == RAND_MAX) begin
        idx_p_d = 1'b1;
      end
    end

    if (exc_tlb) begin
      ctx_bad_d = exc_badVAddr[31:13];
      hi_vpn2_d = exc_badVAddr[31:13];
    end
  end

  // Architectural registers and the read-data holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_p_q    <= 1'b0;
      idx_q      <= '0;
      random_q   <= RAND_MAX;
      wired_q    <= '0;
      lo0_q      <= '0;
      lo1_q      <= '0;
      ctx_base_q <= '0;
      ctx_bad_q  <= '0;
      mask_q     <= '0;
      hi_vpn2_q  <= '0;
      hi_asid_q  <= '0;
      dout_q     <= '0;
    end else begin
      idx_p_q    <= idx_p_d;
      idx_q      <= idx_d;
      random_q   <= random_d;
      wired_q    <= wired_d;
      lo0_q      <= lo0_d;
      lo1_q      <= lo1_d;
      ctx_base_q <= ctx_base_d;
      ctx_bad_q  <= ctx_bad_d;
      mask_q     <= mask_d;
      hi_vpn2_q  <= hi_vpn2_d;
      hi_asid_q  <= hi_asid_d;
      dout_q     <= dout_d;
    end
  end

  // Op sequencer: EXEC is a single cycle, PROBE scans one entry per cycle,
  // DONE raises the registered done pulse as it returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NONE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.tlb_op_valid && bus.tlb_op != OP_NONE) begin
            op_q    <= bus.tlb_op;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= (bus.tlb_op == OP_TLBP) ? ST_PROBE : ST_EXEC;
          end
        end
        ST_EXEC:  state_q <= ST_DONE;
        ST_PROBE: begin
          if (probe_hit || cnt_q == RAND_MAX) state_q <= ST_DONE;
          else                                cnt_q   <= cnt_q + IDX_W'(1);
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mmu_dataOut = dout_q;
  assign bus.tlb_busy    = busy_q;
  assign bus.tlb_done    = done_q;

endmodule
